// File: rtl/store_buffer_ctrl_if.sv
// rtl/store_buffer_ctrl_if.sv - store buffer controller bus bundle
// Purpose: groups the CPU store/load, FIFO and memory write port signals.
// Modports: master = the controller itself, slave = its surroundings
//           (CPU, compare-capable FIFO, memory write port).
interface store_buffer_ctrl_if #(
    parameter int W_ADDR        = 32,
    parameter int W_DATA        = 32,
    parameter int C_NUMBERWORDS = 4
);
    localparam int W_STRB  = W_DATA / 8;
    localparam int W_ENTRY = W_ADDR + W_DATA + W_STRB;

    // CPU store path
    logic                     StReq_i;
    logic [W_ADDR-1:0]        StAddr_i;
    logic [W_DATA-1:0]        StData_i;
    logic [W_STRB-1:0]        StStrb_i;
    logic                     StAck_o;
    // CPU load hazard check
    logic                     LdReq_i;
    logic [W_ADDR-1:0]        LdAddr_i;
    logic                     LdHit_o;
    // flush / status
    logic                     Flush_i;
    logic                     FlushDone_o;
    logic                     Idle_o;
    // FIFO side
    logic                     FifoWrite_o;
    logic                     FifoRead_o;
    logic [W_ENTRY-1:0]       FifoWriteData_o;
    logic                     FifoCompareEn_o;
    logic [W_ADDR-1:0]        FifoCompareData_o;
    logic                     FifoEmpty_i;
    logic                     FifoFull_i;
    logic [W_ENTRY-1:0]       FifoReadData_i;
    logic [C_NUMBERWORDS-1:0] FifoCompareResult_i;
    // memory write port
    logic                     MemReq_o;
    logic [W_ADDR-1:0]        MemAddr_o;
    logic [W_DATA-1:0]        MemData_o;
    logic [W_STRB-1:0]        MemStrb_o;
    logic                     MemAck_i;

    modport master (
        input  StReq_i, StAddr_i, StData_i, StStrb_i,
        output StAck_o,
        input  LdReq_i, LdAddr_i,
        output LdHit_o,
        input  Flush_i,
        output FlushDone_o, Idle_o,
        output FifoWrite_o, FifoRead_o, FifoWriteData_o, FifoCompareEn_o, FifoCompareData_o,
        input  FifoEmpty_i, FifoFull_i, FifoReadData_i, FifoCompareResult_i,
        output MemReq_o, MemAddr_o, MemData_o, MemStrb_o,
        input  MemAck_i
    );

    modport slave (
        output StReq_i, StAddr_i, StData_i, StStrb_i,
        input  StAck_o,
        output LdReq_i, LdAddr_i,
        input  LdHit_o,
        output Flush_i,
        input  FlushDone_o, Idle_o,
        input  FifoWrite_o, FifoRead_o, FifoWriteData_o, FifoCompareEn_o, FifoCompareData_o,
        output FifoEmpty_i, FifoFull_i, FifoReadData_i, FifoCompareResult_i,
        input  MemReq_o, MemAddr_o, MemData_o, MemStrb_o,
        output MemAck_i
    );
endinterface

// File: rtl/store_buffer_ctrl.sv
// rtl/store_buffer_ctrl.sv - store buffer controller in front of the memory write port
// Purpose: accepts CPU stores into a compare-capable FIFO, drains them one at a
//          time over a req/ack memory port, flags load-after-store hazards and
//          sequences flushes.
// Ports:   sClk_i  clock
//          sRst_i  asynchronous active-high reset (also resets the FIFO, inverted)
//          bus     store_buffer_ctrl_if.master: CPU store/load, flush/status,
//                  FIFO command/status, memory write request/ack
module store_buffer_ctrl #(
    parameter int W_ADDR          = 32,
    parameter int W_DATA          = 32,
    parameter int C_NUMBERWORDS   = 4,
    parameter int C_HIGH_WATER    = 3,
    parameter int C_DRAIN_TIMEOUT = 8
) (
    input  logic                sClk_i,
    input  logic                sRst_i,
    store_buffer_ctrl_if.master bus
);
    localparam int W_STRB  = W_DATA / 8;
    localparam int W_ENTRY = W_ADDR + W_DATA + W_STRB;
    localparam int OFF     = $clog2(W_STRB);
    localparam int CNT_W   = $clog2(C_NUMBERWORDS + 1);
    localparam int IDLE_W  = $clog2(C_DRAIN_TIMEOUT + 1);
    localparam logic [W_ADDR-1:0] ALIGN_MASK = ~W_ADDR'((1 << OFF) - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_r;
    state_t             state_nxt;
    logic [CNT_W-1:0]   Count_r;
    logic [IDLE_W-1:0]  IdleCnt_r;
    logic               FlushPend_r;
    logic               FlushDone_r;
    logic [W_ADDR-1:0]  drain_addr_r;
    logic [W_STRB-1:0]  drain_strb_r;
    logic [W_DATA-1:0]  drain_data_r;

    logic [W_ADDR-1:0]  st_addr_al;
    logic [W_ADDR-1:0]  ld_addr_al;
    logic               st_accept;
    logic               ld_hit;
    logic               drain_cond;
    logic               pop;
    logic               flush_fin;

    // Word-align both addresses so compares are per word, not per byte.
    assign st_addr_al = bus.StAddr_i & ALIGN_MASK;
    assign ld_addr_al = bus.LdAddr_i & ALIGN_MASK;

    // A pop this cycle does not free a slot until the next edge.
    assign st_accept = bus.StReq_i & ~bus.FifoFull_i & ~FlushPend_r;

    // The entry being drained has left the FIFO, so it is compared separately.
    assign ld_hit = bus.LdReq_i &
                    ((|bus.FifoCompareResult_i) |
                     ((state_r == BUSY) && (drain_addr_r == ld_addr_al)));

    assign drain_cond = (Count_r >= CNT_W'(C_HIGH_WATER)) |
                        (IdleCnt_r == IDLE_W'(C_DRAIN_TIMEOUT)) |
                        FlushPend_r | ld_hit;

    assign pop = ~bus.FifoEmpty_i & drain_cond &
                 ((state_r == IDLE) | ((state_r == BUSY) & bus.MemAck_i));

    // A flush arriving on an already drained buffer completes at the next
    // edge; a store accepted in the same cycle keeps it pending instead.
    assign flush_fin = (FlushPend_r | bus.Flush_i) & bus.FifoEmpty_i &
                       (state_r == IDLE) & ~st_accept;

    assign bus.StAck_o           = st_accept;
    assign bus.FifoWrite_o       = st_accept;
    assign bus.FifoWriteData_o   = {st_addr_al, bus.StStrb_i, bus.StData_i};
    assign bus.FifoRead_o        = pop;
    assign bus.FifoCompareEn_o   = bus.LdReq_i;
    assign bus.FifoCompareData_o = ld_addr_al;
    assign bus.LdHit_o           = ld_hit;
    assign bus.FlushDone_o       = FlushDone_r;
    assign bus.Idle_o            = bus.FifoEmpty_i & (state_r == IDLE);
    assign bus.MemReq_o          = (state_r == BUSY);
    assign bus.MemAddr_o         = drain_addr_r;
    assign bus.MemData_o         = drain_data_r;
    assign bus.MemStrb_o         = drain_strb_r;

    always_ff @(posedge sClk_i or posedge sRst_i) begin
        if (sRst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // An ack with a pop keeps BUSY so back-to-back transfers have no bubble.
    always_comb begin
        state_nxt = state_r;
        if (pop) begin
            state_nxt = BUSY;
        end else if ((state_r == BUSY) && bus.MemAck_i) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge sClk_i or posedge sRst_i) begin
        if (sRst_i) begin
            Count_r      <= '0;
            IdleCnt_r    <= '0;
            FlushPend_r  <= 1'b0;
            FlushDone_r  <= 1'b0;
            drain_addr_r <= '0;
            drain_strb_r <= '0;
            drain_data_r <= '0;
        end else begin
            case ({st_accept, pop})
                2'b10:   Count_r <= Count_r + CNT_W'(1);
                2'b01:   Count_r <= Count_r - CNT_W'(1);
                default: Count_r <= Count_r;
            endcase

            if (st_accept || bus.FifoEmpty_i) begin
                IdleCnt_r <= '0;
            end else if (IdleCnt_r != IDLE_W'(C_DRAIN_TIMEOUT)) begin
                IdleCnt_r <= IdleCnt_r + IDLE_W'(1);
            end

            FlushDone_r <= flush_fin;
            if (flush_fin) begin
                FlushPend_r <= 1'b0;
            end else if (bus.Flush_i) begin
                FlushPend_r <= 1'b1;
            end

            if (pop) begin
                drain_addr_r <= bus.FifoReadData_i[W_ENTRY-1 -: W_ADDR];
                drain_strb_r <= bus.FifoReadData_i[W_DATA +: W_STRB];
                drain_data_r <= bus.FifoReadData_i[W_DATA-1:0];
            end
        end
    end
endmodule
